// File: rtl/io_pin_bridge_pkg.sv
// io_pin_bridge_pkg
// Shared constants for the GPIO pin bridge: bulk port index helpers and the
// pin direction encoding. No ports.
package io_pin_bridge_pkg;

    // Direction encoding used on pin_dir
    localparam logic DIR_OUT = 1'b1;

    // Defaults used by the top level and the bench
    localparam int IO_PINS_DEFAULT    = 4;
    localparam int DATA_WIDTH_DEFAULT = 8;

    // Bulk write port sits right after the per-pin ports, bulk read after that
    function automatic int bulk_wr_idx(input int io_pins);
        return io_pins;
    endfunction

    function automatic int bulk_rd_idx(input int io_pins);
        return io_pins + 1;
    endfunction

endpackage

// File: rtl/io_pin_bridge_if.sv
// io_pin_bridge_if
// Message-port bundle between the CPU/memory interconnect and the pin bridge.
// Ports:
//   port_active_in   bridge -> CPU, one-cycle valid pulse per port
//   port_data_in     bridge -> CPU, port k at bits k*DATA_WIDTH +: DATA_WIDTH
//   port_active_out  CPU -> bridge, one-cycle valid strobe per port
//   port_data_out    CPU -> bridge, same packing
// Modports: master = CPU side, slave = bridge side.
interface io_pin_bridge_if #(
    parameter int IO_PINS    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int NPORTS = IO_PINS + 2;

    logic [NPORTS-1:0]            port_active_in;
    logic [NPORTS-1:0]            port_active_out;
    logic [NPORTS*DATA_WIDTH-1:0] port_data_in;
    logic [NPORTS*DATA_WIDTH-1:0] port_data_out;

    modport master (
        input  port_active_in,
        input  port_data_in,
        output port_active_out,
        output port_data_out
    );

    modport slave (
        output port_active_in,
        output port_data_in,
        input  port_active_out,
        input  port_data_out
    );

endinterface

// File: rtl/io_pin_sync.sv
// io_pin_sync
// Two-flop synchronizer for asynchronous pad levels.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   d         asynchronous input vector
//   q         synchronized output (second stage)
module io_pin_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_d, meta_q;
    logic [WIDTH-1:0] sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/io_pin_bridge.sv
// io_pin_bridge
// Bridges IO_PINS GPIO pins to IO_PINS+2 message ports.
//   ports 0..IO_PINS-1 : one port per pin (write drives output pin, read
//                        reports input pin changes)
//   port IO_PINS       : bulk write, drives all output pins at once
//   port IO_PINS+1     : bulk read, reports any input pin change
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   pin_dir       per-pin direction, 1 = output
//   pin_data_in   raw pad levels (asynchronous)
//   pin_data_out  registered output levels to the pads
//   bus           message ports (slave side of io_pin_bridge_if)
module io_pin_bridge
    import io_pin_bridge_pkg::*;
#(
    parameter int IO_PINS    = IO_PINS_DEFAULT,
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IO_PINS-1:0] pin_dir,
    input  logic [IO_PINS-1:0] pin_data_in,
    output logic [IO_PINS-1:0] pin_data_out,
    io_pin_bridge_if.slave     bus
);

    localparam int NPORTS  = IO_PINS + 2;
    localparam int BULK_WR = bulk_wr_idx(IO_PINS);
    localparam int BULK_RD = bulk_rd_idx(IO_PINS);

    logic [IO_PINS-1:0]            sync2;
    logic [IO_PINS-1:0]            prev_d, prev_q;
    logic [IO_PINS-1:0]            out_d, out_q;
    logic [IO_PINS-1:0]            chg;
    logic [IO_PINS-1:0]            is_out;
    logic [IO_PINS-1:0]            rd_vec;
    logic [NPORTS-1:0]             active_in_d, active_in_q;
    logic [NPORTS*DATA_WIDTH-1:0]  data_in_d, data_in_q;

    // Bulk-read data slice and the upper bits of per-pin write data are never used.
    logic unused_bus;
    assign unused_bus = ^bus.port_data_out ^ bus.port_active_out[BULK_RD];

    io_pin_sync #(.WIDTH(IO_PINS)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (pin_data_in),
        .q   (sync2)
    );

    // prev tracks sync2 regardless of direction so a direction flip never
    // exposes a stale level as a change.
    assign prev_d = sync2;

    for (genvar p = 0; p < IO_PINS; p++) begin : g_pin
        assign is_out[p] = (pin_dir[p] == DIR_OUT);
        assign chg[p]    = (sync2[p] != prev_q[p]) && !is_out[p];
        assign rd_vec[p] = is_out[p] ? out_q[p] : sync2[p];

        // Per-pin strobe takes priority over the bulk write for the same pin.
        assign out_d[p] = !is_out[p]                  ? out_q[p] :
                          bus.port_active_out[p]       ? bus.port_data_out[p*DATA_WIDTH] :
                          bus.port_active_out[BULK_WR] ? bus.port_data_out[BULK_WR*DATA_WIDTH + p] :
                                                         out_q[p];

        assign active_in_d[p] = chg[p];
        assign data_in_d[p*DATA_WIDTH +: DATA_WIDTH] =
            chg[p] ? DATA_WIDTH'(sync2[p]) : data_in_q[p*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        active_in_d[BULK_WR] = 1'b0;
        active_in_d[BULK_RD] = |chg;
        data_in_d[BULK_WR*DATA_WIDTH +: DATA_WIDTH] = '0;
        data_in_d[BULK_RD*DATA_WIDTH +: DATA_WIDTH] =
            (|chg) ? DATA_WIDTH'(rd_vec) : data_in_q[BULK_RD*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q      <= '0;
            out_q       <= '0;
            active_in_q <= '0;
            data_in_q   <= '0;
        end else begin
            prev_q      <= prev_d;
            out_q       <= out_d;
            active_in_q <= active_in_d;
            data_in_q   <= data_in_d;
        end
    end

    assign pin_data_out       = out_q;
    assign bus.port_active_in = active_in_q;
    assign bus.port_data_in   = data_in_q;

endmodule

// File: tb/tb_io_pin_bridge.sv
// tb_io_pin_bridge
// Directed bench for io_pin_bridge with IO_PINS=4, DATA_WIDTH=8.
module tb_io_pin_bridge;

    localparam int NP = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [NP-1:0] pin_dir;
    logic [NP-1:0] pin_in;
    logic [NP-1:0] pin_out;

    int checks = 0;
    int passed = 0;

    io_pin_bridge_if #(.IO_PINS(NP), .DATA_WIDTH(DW)) bus ();

    io_pin_bridge #(.IO_PINS(NP), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .pin_dir      (pin_dir),
        .pin_data_in  (pin_in),
        .pin_data_out (pin_out),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d passed=%0d", checks, passed);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int k, input logic [DW-1:0] v);
        bus.port_data_out[k*DW +: DW] = v;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pin_dir = '0;
        pin_in = '0;
        bus.port_active_out = '0;
        bus.port_data_out = '0;
        repeat (2) tick();
        pin_in = 4'hF;
        repeat (2) tick();
        checks++;
        if (pin_out !== 4'h0) $display("FAIL reset_pin_out: got %b expected 0000", pin_out);
        else passed++;
        checks++;
        if (bus.port_active_in !== 6'b0) $display("FAIL reset_active_in: got %b expected 000000", bus.port_active_in);
        else passed++;
        checks++;
        if (bus.port_data_in !== 48'h0) $display("FAIL reset_data_in: got %h expected 0", bus.port_data_in);
        else passed++;
        pin_in = '0;
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if (bus.port_active_in !== 6'b0) $display("FAIL reset_release_active: got %b expected 000000", bus.port_active_in);
        else passed++;
    endtask

    task automatic test_input_edge();
        pin_dir = 4'b0101;
        pin_in = 4'b0000;
        repeat (3) tick();
        pin_in = 4'b1000;
        tick();
        checks++;
        if (bus.port_active_in !== 6'b0) $display("FAIL edge_lat1: got %b expected 000000", bus.port_active_in);
        else passed++;
        tick();
        checks++;
        if (bus.port_active_in !== 6'b0) $display("FAIL edge_lat2: got %b expected 000000", bus.port_active_in);
        else passed++;
        tick();
        checks++;
        if (bus.port_active_in !== 6'b101000) $display("FAIL edge_pulse: got %b expected 101000", bus.port_active_in);
        else passed++;
        checks++;
        if (bus.port_data_in[3*DW +: DW] !== 8'h01) $display("FAIL edge_data3: got %h expected 01", bus.port_data_in[3*DW +: DW]);
        else passed++;
        checks++;
        if (bus.port_data_in[5*DW +: DW] !== 8'h08) $display("FAIL edge_data5: got %h expected 08", bus.port_data_in[5*DW +: DW]);
        else passed++;
        tick();
        checks++;
        if (bus.port_active_in !== 6'b0) $display("FAIL edge_one_cycle: got %b expected 000000", bus.port_active_in);
        else passed++;
        checks++;
        if (bus.port_data_in[3*DW +: DW] !== 8'h01) $display("FAIL edge_data_hold: got %h expected 01", bus.port_data_in[3*DW +: DW]);
        else passed++;
    endtask

    task automatic test_per_pin_write();
        set_port(2, 8'hFF);
        set_port(0, 8'hFF);
        bus.port_active_out = 6'b000100;
        tick();
        bus.port_active_out = '0;
        checks++;
        if (pin_out !== 4'b0100) $display("FAIL perpin_write: got %b expected 0100", pin_out);
        else passed++;
        set_port(1, 8'hFF);
        bus.port_active_out = 6'b000010;
        tick();
        bus.port_active_out = '0;
        tick();
        checks++;
        if (pin_out !== 4'b0100) $display("FAIL perpin_input_ignored: got %b expected 0100", pin_out);
        else passed++;
        checks++;
        if (bus.port_active_in !== 6'b0) $display("FAIL perpin_no_event: got %b expected 000000", bus.port_active_in);
        else passed++;
    endtask

    task automatic test_bulk_write();
        set_port(4, 8'h0F);
        bus.port_active_out = 6'b010000;
        tick();
        bus.port_active_out = '0;
        checks++;
        if (pin_out !== 4'b0101) $display("FAIL bulk_write_all: got %b expected 0101", pin_out);
        else passed++;
        set_port(4, 8'h01);
        bus.port_active_out = 6'b010000;
        tick();
        bus.port_active_out = '0;
        checks++;
        if (pin_out !== 4'b0001) $display("FAIL bulk_write_01: got %b expected 0001", pin_out);
        else passed++;
        set_port(5, 8'hFF);
        bus.port_active_out = 6'b100000;
        tick();
        bus.port_active_out = '0;
        tick();
        checks++;
        if (pin_out !== 4'b0001) $display("FAIL bulk_read_port_write_ignored: got %b expected 0001", pin_out);
        else passed++;
    endtask

    task automatic test_collision();
        set_port(4, 8'h03);
        set_port(0, 8'h00);
        bus.port_active_out = 6'b010001;
        tick();
        bus.port_active_out = '0;
        checks++;
        if (pin_out !== 4'b0000) $display("FAIL collision: got %b expected 0000", pin_out);
        else passed++;
    endtask

    task automatic test_bulk_read();
        int          npulse;
        logic [5:0]  snap_ai;
        logic [7:0]  snap_d5;
        logic [7:0]  snap_d3;
        set_port(4, 8'h05);
        bus.port_active_out = 6'b010000;
        tick();
        bus.port_active_out = '0;
        checks++;
        if (pin_out !== 4'b0101) $display("FAIL bulk_read_setup: got %b expected 0101", pin_out);
        else passed++;
        pin_in = 4'b1010;
        repeat (3) tick();
        checks++;
        if (bus.port_active_in !== 6'b100010) $display("FAIL bulk_read_pulse: got %b expected 100010", bus.port_active_in);
        else passed++;
        checks++;
        if (bus.port_data_in[5*DW +: DW] !== 8'h0F) $display("FAIL bulk_read_mixed: got %h expected 0f", bus.port_data_in[5*DW +: DW]);
        else passed++;
        checks++;
        if (bus.port_data_in[1*DW +: DW] !== 8'h01) $display("FAIL bulk_read_data1: got %h expected 01", bus.port_data_in[1*DW +: DW]);
        else passed++;
        pin_in = 4'b0000;
        npulse = 0;
        snap_ai = '0;
        snap_d5 = 8'hAA;
        snap_d3 = 8'hAA;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.port_active_in[5]) begin
                npulse++;
                snap_ai = bus.port_active_in;
                snap_d5 = bus.port_data_in[5*DW +: DW];
                snap_d3 = bus.port_data_in[3*DW +: DW];
            end
        end
        checks++;
        if (npulse !== 1) $display("FAIL simul_one_pulse: got %0d pulses expected 1", npulse);
        else passed++;
        checks++;
        if (snap_ai !== 6'b101010) $display("FAIL simul_active: got %b expected 101010", snap_ai);
        else passed++;
        checks++;
        if (snap_d5 !== 8'h05) $display("FAIL simul_data5: got %h expected 05", snap_d5);
        else passed++;
        checks++;
        if (snap_d3 !== 8'h00) $display("FAIL simul_data3: got %h expected 00", snap_d3);
        else passed++;
    endtask

    task automatic test_dir_flip();
        logic [5:0] acc;
        pin_in = 4'b0010;
        repeat (5) tick();
        pin_dir = 4'b0111;
        acc = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            acc = acc | bus.port_active_in;
        end
        checks++;
        if (acc !== 6'b0) $display("FAIL dirflip_to_out: got %b expected 000000", acc);
        else passed++;
        pin_in = 4'b0000;
        acc = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            acc = acc | bus.port_active_in;
        end
        checks++;
        if (acc !== 6'b0) $display("FAIL dirflip_masked_change: got %b expected 000000", acc);
        else passed++;
        pin_dir = 4'b0101;
        acc = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            acc = acc | bus.port_active_in;
        end
        checks++;
        if (acc !== 6'b0) $display("FAIL dirflip_back_to_in: got %b expected 000000", acc);
        else passed++;
        checks++;
        if (pin_out !== 4'b0101) $display("FAIL dirflip_pin_out: got %b expected 0101", pin_out);
        else passed++;
    endtask

    task automatic test_reset_abort();
        logic [5:0] acc;
        pin_in = 4'b1000;
        repeat (3) tick();
        checks++;
        if (bus.port_active_in !== 6'b101000) $display("FAIL abort_pre_pulse: got %b expected 101000", bus.port_active_in);
        else passed++;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.port_active_in !== 6'b0) $display("FAIL abort_active_cleared: got %b expected 000000", bus.port_active_in);
        else passed++;
        checks++;
        if (bus.port_data_in !== 48'h0) $display("FAIL abort_data_cleared: got %h expected 0", bus.port_data_in);
        else passed++;
        checks++;
        if (pin_out !== 4'b0000) $display("FAIL abort_pin_out: got %b expected 0000", pin_out);
        else passed++;
        pin_in = 4'b0000;
        repeat (3) tick();
        rst = 1'b0;
        acc = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            acc = acc | bus.port_active_in;
        end
        checks++;
        if (acc !== 6'b0) $display("FAIL abort_quiet_after: got %b expected 000000", acc);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_input_edge();
        test_per_pin_write();
        test_bulk_write();
        test_collision();
        test_bulk_read();
        test_dir_flip();
        test_reset_abort();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/io_pin_bridge.md
Name: io_pin_bridge

Overview:
- Bridges IO_PINS single-bit GPIO pins to IO_PINS+2 DATA_WIDTH-wide message ports on the CPU/memory interconnect.
- Ports 0..IO_PINS-1 map one-to-one to pins.
- Port IO_PINS is a write-only bulk port that drives all output pins at once.
- Port IO_PINS+1 is a read-only bulk port that reports every pin change.
- Direction per pin is set by pin_dir (1 = output, 0 = input).

Parameters:
IO_PINS, 4, number of GPIO pins.
DATA_WIDTH, 8, port message width; must be >= IO_PINS.

Ports:
clk  in  1  single clock, all state on rising edge.
rst  in  1  asynchronous, active-high reset.
pin_dir  in  IO_PINS  per-pin direction, 1 = output, 0 = input.
pin_data_in  in  IO_PINS  raw pin levels from the pads (asynchronous).
pin_data_out  out  IO_PINS  registered output levels to the pads.
port_active_in  out  IO_PINS+2  one-cycle valid pulse per port, bridge to CPU.
port_active_out  in  IO_PINS+2  one-cycle valid strobe per port, CPU to bridge.
port_data_in  out  (IO_PINS+2)*DATA_WIDTH  message data to CPU; port k occupies bits k*DATA_WIDTH +: DATA_WIDTH.
port_data_out  in  (IO_PINS+2)*DATA_WIDTH  message data from CPU, same packing.

Behaviour:
- Reset (async, rst=1) clears: out_reg, both synchronizer stages, prev_reg, pin_data_out, port_active_in and port_data_in. All outputs read 0.
- Input path:
  - pin_data_in passes through a 2-flop synchronizer (sync2); prev_reg <= sync2 every cycle.
  - chg[p] = (sync2[p] != prev_reg[p]) && !pin_dir[p].
  - Registered outputs for per-pin port p, when chg[p]: port_active_in[p] = 1 for one cycle; port_data_in[p] = zero-extended sync2[p].
  - Latency: a pad change before edge N gives port_active_in high after edge N+2, for one cycle.
- Bulk read, port IO_PINS+1:
  - Pulses when any chg bit is set; simultaneous changes produce one pulse.
  - Data = zero-extended vector: input pins show sync2, output pins show out_reg.
- port_data_in holds its last value between pulses.
- port_active_in[IO_PINS] and its data slice are tied to 0.
- Output path, per-pin port p:
  - On port_active_out[p] with pin_dir[p]=1: out_reg[p] <= bit 0 of port p data.
  - Strobes to input pins are ignored; out_reg is unchanged.
- Bulk write, port IO_PINS:
  - On port_active_out[IO_PINS]: every output pin p takes bit p of the port data.
  - Input pins are unaffected.
- Simultaneous per-pin and bulk write to the same pin: the per-pin port wins.
- port_active_out[IO_PINS+1] and its data are ignored.
- pin_data_out = out_reg, registered, so a write strobe sampled at edge N appears after edge N.
- Direction change does not cause a spurious event: prev_reg always tracks sync2, and chg is masked by the current pin_dir.
- Reset asserted mid-operation aborts pending pulses immediately.

Decomposition:
- Shared package: port index constants (BULK_WR = IO_PINS, BULK_RD = IO_PINS+1) and a direction encoding constant (DIR_OUT = 1).
- One sub-module, io_pin_sync: a parameterised 2-flop synchronizer with async reset, instantiated over the IO_PINS vector.
- All port logic stays in the top level, built with generate loops per pin.

Test Plan:
- Reset: hold rst=1 for 4 cycles -> all outputs 0, including after pins toggle.
- Input edge: pin_dir=0101, pin_data_in 0000->1000 -> port_active_in=100000 and 001000 on the same single cycle, 3 edges later. port_data_in[3]=0x01 and port_data_in[5]=0x08 (pins 0 and 2 read out_reg=0).
- Per-pin write: port_active_out=000100, port 2 data=0xFF, port 0 data=0xFF -> pin_data_out=0100, pin 0 stays 0. Then strobe port 1 (an input pin) -> no change.
- Bulk write: port_active_out=010000, port 4 data=0x01 -> pin_data_out=0001 (pin 2 cleared, pins 1 and 3 ignored).
- Collision: port_active_out=010001, port 4 data=0x03, port 0 data=0x00 -> pin_data_out=0000 (per-pin wins for pin 0, bulk clears pin 2).
- Direction flip: pin_dir 0101->0111 with pin 1 steady high -> no port_active_in pulse.
